// File: rtl/step_if.sv
// step_if: button, run-control and motor-drive signals of the stepper phase sequencer.
interface step_if;
  logic       btn_up;
  logic       btn_down;
  logic       enable;
  logic       dir;
  logic [2:0] speed;
  logic [3:0] coils;
  logic       step_pulse;
  logic       running;
  modport master (output btn_up, btn_down, enable, dir, input speed, coils, step_pulse, running);
  modport slave  (input btn_up, btn_down, enable, dir, output speed, coils, step_pulse, running);
endinterface

// File: rtl/step_sequencer.sv
// step_sequencer: speed-controlled stepper phase sequencer with button-stepped speed 0..7.
// Define STEP_HALF_STEP_EN for the 8-entry half-step table; default is 4-entry full-step.
module step_sequencer #(
  parameter int BASE_DIV = 50000
) (
  input logic   clk,
  input logic   rst_n,
  step_if.slave io
);
`ifdef STEP_HALF_STEP_EN
  localparam int PW = 3;
  localparam logic [31:0] TBL = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                 4'b0110, 4'b0010, 4'b0011, 4'b0001};
`else
  localparam int PW = 2;
  localparam logic [15:0] TBL = {4'b1001, 4'b1100, 4'b0110, 4'b0011};
`endif
  localparam int PRW = (BASE_DIV > 2) ? $clog2(BASE_DIV) : 1;
  typedef enum logic {IDLE, RUN} state_e;
  state_e         state_q, state_d;
  logic [2:0]     speed_q, speed_d, cnt_q, cnt_d;
  logic [PRW-1:0] pre_q, pre_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [3:0]     coils_q, coils_d;
  logic           up_q, dn_q, step_q, step_d, running_q, running_d;
  logic           up_e, dn_e, run, stay, tick, step;
  always_comb begin
    up_e      = io.btn_up & ~up_q;
    dn_e      = io.btn_down & ~dn_q;
    speed_d   = (up_e && !dn_e && speed_q != 3'd7) ? speed_q + 3'd1 :
                (dn_e && !up_e && speed_q != 3'd0) ? speed_q - 3'd1 : speed_q;
    run       = state_q == RUN;
    state_d   = (io.enable && speed_q != 3'd0) ? RUN : IDLE;
    stay      = run && state_d == RUN;
    tick      = stay && pre_q == PRW'(BASE_DIV - 1);
    // limit tracks the live speed, so a counter already past it fires on this tick
    step      = tick && cnt_q >= 3'd7 - speed_q;
    pre_d     = (!stay || tick) ? '0 : pre_q + PRW'(1);
    cnt_d     = (!stay || step) ? 3'd0 : tick ? cnt_q + 3'd1 : cnt_q;
    phase_d   = step ? (io.dir ? phase_q + PW'(1) : phase_q - PW'(1)) : phase_q;
    coils_d   = (state_d == RUN) ? TBL[{phase_d, 2'b00} +: 4] : 4'b0000;
    step_d    = step;
    running_d = state_d == RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      speed_q   <= '0;
      cnt_q     <= '0;
      pre_q     <= '0;
      phase_q   <= '0;
      coils_q   <= '0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      step_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      speed_q   <= speed_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      phase_q   <= phase_d;
      coils_q   <= coils_d;
      up_q      <= io.btn_up;
      dn_q      <= io.btn_down;
      step_q    <= step_d;
      running_q <= running_d;
    end
  assign io.speed      = speed_q;
  assign io.coils      = coils_q;
  assign io.step_pulse = step_q;
  assign io.running    = running_q;
endmodule
